// File: rtl/mul_sched_pkg.sv
// Shared types and default sizing for the multiplier scheduler.
package mul_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ACC    = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/mul_scheduler_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr_i+1 upward, wrapping to 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            vld_o
);

  int            c;
  logic [IDW-1:0] cur;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    c     = 0;
    cur   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = int'(ptr_i) + k;
      if (c >= NREQ) c = c - NREQ;
      cur = IDW'(c);
      if (!vld_o && req_i[cur]) begin
        vld_o      = 1'b1;
        idx_o      = cur;
        gnt_o[cur] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Round-robin sequencer sharing one repeated-addition multiplier among NREQ clients.
// Optional sticky overflow output rsp_ovf when MUL_SCHED_OVF_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a request; arbiter winner captured on the edge
// LOAD_A | multiplicand on dp_bus, ldA
// LOAD_B | multiplier on dp_bus, ldB + clrP
// ACC    | ldP/decB each cycle until eqz, then latch product
// DONE   | rsp_valid pulse
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      dp_bus,
  output logic                  ldA,
  output logic                  ldB,
  output logic                  ldP,
  output logic                  clrP,
  output logic                  decB,
  input  logic                  eqz,
  input  logic [WIDTH-1:0]      dp_p
`ifdef MUL_SCHED_OVF_EN
  ,output logic                 rsp_ovf
`endif
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, rsp_data_q;
  logic [IDW-1:0]   owner_q, ptr_q, rsp_id_q;
  logic [NREQ-1:0]  gnt_q;

  logic [NREQ-1:0]  win_oh;
  logic [IDW-1:0]   win_idx;
  logic             win_vld;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      owner_q    <= '0;
      ptr_q      <= IDW'(NREQ - 1);
      gnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      gnt_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            a_q     <= a_in[win_idx*WIDTH +: WIDTH];
            b_q     <= b_in[win_idx*WIDTH +: WIDTH];
            owner_q <= win_idx;
            ptr_q   <= win_idx;
            gnt_q   <= win_oh;
            state_q <= LOAD_A;
          end
        end
        LOAD_A: state_q <= LOAD_B;
        LOAD_B: state_q <= ACC;
        ACC: begin
          if (eqz) begin
            rsp_data_q <= dp_p;
            rsp_id_q   <= owner_q;
            state_q    <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Controls depend only on registered state (plus eqz for the ACC loop).
  always_comb begin
    dp_bus = '0;
    unique case (state_q)
      LOAD_A:  dp_bus = a_q;
      LOAD_B:  dp_bus = b_q;
      default: dp_bus = '0;
    endcase
  end

  assign ldA       = (state_q == LOAD_A);
  assign ldB       = (state_q == LOAD_B);
  assign clrP      = (state_q == LOAD_B);
  assign ldP       = (state_q == ACC) && !eqz;
  assign decB      = (state_q == ACC) && !eqz;
  assign rsp_valid = (state_q == DONE);
  assign gnt       = gnt_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef MUL_SCHED_OVF_EN
  logic [WIDTH:0] sum_ext;
  logic           ovf_q;

  assign sum_ext = {1'b0, dp_p} + {1'b0, a_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == LOAD_B) begin
      ovf_q <= 1'b0;
    end else if (ldP && sum_ext[WIDTH]) begin
      ovf_q <= 1'b1;
    end
  end

  assign rsp_ovf = ovf_q;
`endif

endmodule
